// File: rtl/eep_arb.sv
// Two-requester round-robin EEPROM access arbiter with write charge-pump sequencing.
// All EEPROM-side and handshake outputs come straight from flops.
module eep_arb #(
  parameter int unsigned PMP_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic        a_wr,
  input  logic [1:0]  a_addr,
  input  logic [13:0] a_wdata,
  output logic        a_gnt,
  output logic        a_done,
  input  logic        b_req,
  input  logic        b_wr,
  input  logic [1:0]  b_addr,
  input  logic [13:0] b_wdata,
  output logic        b_gnt,
  output logic        b_done,
  output logic [13:0] rd_data,
  input  logic [13:0] eep_rd_data,
  output logic        eep_cs_n,
  output logic        eep_r_w_n,
  output logic [1:0]  eep_addr,
  output logic [13:0] eep_wr_data,
  output logic        chrg_pmp_en,
  output logic        busy
);

  localparam int unsigned AW = 2;
  localparam int unsigned DW = 14;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {IDLE, ACCESS, PUMP, DONE} state_e;

  state_e        state_q, state_d;
  logic          last_b_q, last_b_d;
  logic          sel_b_q, sel_b_d;
  logic          wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic [AW-1:0] eep_addr_q, eep_addr_d;
  logic [DW-1:0] eep_wr_data_q, eep_wr_data_d;
  logic          eep_cs_n_q, eep_cs_n_d;
  logic          eep_r_w_n_q, eep_r_w_n_d;
  logic          pmp_q, pmp_d;
  logic          busy_q, busy_d;
  logic          a_gnt_q, a_gnt_d;
  logic          b_gnt_q, b_gnt_d;
  logic          a_done_q, a_done_d;
  logic          b_done_q, b_done_d;
  logic          pick_b;

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    last_b_d      = last_b_q;
    sel_b_d       = sel_b_q;
    wr_d          = wr_q;
    cnt_d         = cnt_q;
    rd_data_d     = rd_data_q;
    eep_addr_d    = eep_addr_q;
    eep_wr_data_d = eep_wr_data_q;
    eep_cs_n_d    = 1'b1;
    eep_r_w_n_d   = 1'b1;
    pmp_d         = pmp_q;
    a_gnt_d       = 1'b0;
    b_gnt_d       = 1'b0;
    a_done_d      = 1'b0;
    b_done_d      = 1'b0;
    pick_b        = 1'b0;

    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          // On a conflict the side not granted last wins.
          pick_b        = b_req && (!a_req || !last_b_q);
          state_d       = ACCESS;
          sel_b_d       = pick_b;
          last_b_d      = pick_b;
          wr_d          = pick_b ? b_wr : a_wr;
          eep_addr_d    = pick_b ? b_addr : a_addr;
          eep_wr_data_d = pick_b ? b_wdata : a_wdata;
          eep_cs_n_d    = 1'b0;
          eep_r_w_n_d   = pick_b ? ~b_wr : ~a_wr;
          a_gnt_d       = !pick_b;
          b_gnt_d       = pick_b;
        end
      end
      ACCESS: begin
        if (wr_q) begin
          state_d = PUMP;
          pmp_d   = 1'b1;
          cnt_d   = CW'(PMP_CYCLES);
        end else begin
          state_d   = DONE;
          rd_data_d = eep_rd_data;
          a_done_d  = !sel_b_q;
          b_done_d  = sel_b_q;
        end
      end
      PUMP: begin
        if (cnt_q <= CW'(1)) begin
          state_d  = DONE;
          pmp_d    = 1'b0;
          a_done_d = !sel_b_q;
          b_done_d = sel_b_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        pmp_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_b_q      <= 1'b1;
      sel_b_q       <= 1'b0;
      wr_q          <= 1'b0;
      cnt_q         <= '0;
      rd_data_q     <= '0;
      eep_addr_q    <= '0;
      eep_wr_data_q <= '0;
      eep_cs_n_q    <= 1'b1;
      eep_r_w_n_q   <= 1'b1;
      pmp_q         <= 1'b0;
      busy_q        <= 1'b0;
      a_gnt_q       <= 1'b0;
      b_gnt_q       <= 1'b0;
      a_done_q      <= 1'b0;
      b_done_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_b_q      <= last_b_d;
      sel_b_q       <= sel_b_d;
      wr_q          <= wr_d;
      cnt_q         <= cnt_d;
      rd_data_q     <= rd_data_d;
      eep_addr_q    <= eep_addr_d;
      eep_wr_data_q <= eep_wr_data_d;
      eep_cs_n_q    <= eep_cs_n_d;
      eep_r_w_n_q   <= eep_r_w_n_d;
      pmp_q         <= pmp_d;
      busy_q        <= busy_d;
      a_gnt_q       <= a_gnt_d;
      b_gnt_q       <= b_gnt_d;
      a_done_q      <= a_done_d;
      b_done_q      <= b_done_d;
    end
  end

  assign a_gnt       = a_gnt_q;
  assign b_gnt       = b_gnt_q;
  assign a_done      = a_done_q;
  assign b_done      = b_done_q;
  assign rd_data     = rd_data_q;
  assign eep_cs_n    = eep_cs_n_q;
  assign eep_r_w_n   = eep_r_w_n_q;
  assign eep_addr    = eep_addr_q;
  assign eep_wr_data = eep_wr_data_q;
  assign chrg_pmp_en = pmp_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_eep_arb.sv
// Bench for eep_arb: directed scenarios plus random traffic against a
// transaction-timeline reference model.
module tb_eep_arb;

  localparam int unsigned P = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_wr, b_req, b_wr;
  logic [1:0]  a_addr, b_addr;
  logic [13:0] a_wdata, b_wdata, eep_rd_data;
  logic        a_gnt, a_done, b_gnt, b_done;
  logic [13:0] rd_data, eep_wr_data;
  logic        eep_cs_n, eep_r_w_n, chrg_pmp_en, busy;
  logic [1:0]  eep_addr;

  int checks = 0;
  int errors = 0;

  eep_arb #(.PMP_CYCLES(P)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done),
    .rd_data(rd_data), .eep_rd_data(eep_rd_data),
    .eep_cs_n(eep_cs_n), .eep_r_w_n(eep_r_w_n),
    .eep_addr(eep_addr), .eep_wr_data(eep_wr_data),
    .chrg_pmp_en(chrg_pmp_en), .busy(busy)
  );

  always #5 clk = ~clk;

  // Transaction timeline model: cycle k=1 is the grant cycle; a read ends
  // at k=2, a write pumps for k=2..P+1 and ends at k=P+2.
  bit          m_active;
  int          m_k;
  int          m_len;
  bit          m_sel_b;
  bit          m_last_b;
  bit          m_wr;
  logic [1:0]  m_addr;
  logic [13:0] m_wdata;
  logic [13:0] m_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, want, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_k      = 0;
    m_len    = 0;
    m_sel_b  = 1'b0;
    m_last_b = 1'b1;
    m_wr     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_rd     = '0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (m_active) begin
      if (m_k == 1 && !m_wr) m_rd = eep_rd_data;
      m_k++;
      if (m_k > m_len) m_active = 1'b0;
    end else if (a_req || b_req) begin
      if (a_req && b_req) m_sel_b = !m_last_b;
      else                m_sel_b = b_req;
      m_last_b = m_sel_b;
      m_wr     = m_sel_b ? b_wr : a_wr;
      m_addr   = m_sel_b ? b_addr : a_addr;
      m_wdata  = m_sel_b ? b_wdata : a_wdata;
      m_len    = m_wr ? int'(P) + 2 : 2;
      m_k      = 1;
      m_active = 1'b1;
    end
  endtask

  task automatic compare();
    bit acc, pump, fin;
    acc  = m_active && (m_k == 1);
    pump = m_active && m_wr && (m_k >= 2) && (m_k <= int'(P) + 1);
    fin  = m_active && (m_k == m_len);
    chk("a_gnt",       32'(a_gnt),       32'(acc && !m_sel_b));
    chk("b_gnt",       32'(b_gnt),       32'(acc && m_sel_b));
    chk("a_done",      32'(a_done),      32'(fin && !m_sel_b));
    chk("b_done",      32'(b_done),      32'(fin && m_sel_b));
    chk("eep_cs_n",    32'(eep_cs_n),    32'(!acc));
    chk("eep_r_w_n",   32'(eep_r_w_n),   32'(acc ? !m_wr : 1'b1));
    chk("eep_addr",    32'(eep_addr),    32'(m_addr));
    chk("eep_wr_data", 32'(eep_wr_data), 32'(m_wdata));
    chk("chrg_pmp_en", 32'(chrg_pmp_en), 32'(pump));
    chk("busy",        32'(busy),        32'(m_active));
    chk("rd_data",     32'(rd_data),     32'(m_rd));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    compare();
  endtask

  task automatic drv(input logic ar, input logic aw, input logic [1:0] aa, input logic [13:0] ad,
                     input logic br, input logic bw, input logic [1:0] ba, input logic [13:0] bd);
    @(negedge clk);
    a_req = ar; a_wr = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_wr = bw; b_addr = ba; b_wdata = bd;
  endtask

  initial begin
    rst = 1'b1;
    eep_rd_data = '0;
    a_req = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_wr = 0; b_addr = '0; b_wdata = '0;
    model_reset();
    #1;
    compare();
    tick();
    @(negedge clk);
    rst = 1'b0;

    // A reads addr 2, EEPROM returns 1A5C.
    eep_rd_data = 14'h1A5C;
    drv(1, 0, 2'd2, 14'h0, 0, 0, 2'd0, 14'h0);
    tick();
    drv(0, 0, 2'd0, 14'h0, 0, 0, 2'd0, 14'h0);
    for (int i = 0; i < 3; i++) tick();
    chk("read_1a5c", 32'(rd_data), 32'h1A5C);

    // B writes 3FFF to addr 3; rd_data must stay.
    drv(0, 0, 2'd0, 14'h0, 1, 1, 2'd3, 14'h3FFF);
    tick();
    drv(0, 0, 2'd0, 14'h0, 0, 0, 2'd0, 14'h0);
    for (int i = 0; i < int'(P) + 3; i++) tick();
    chk("rd_after_wr", 32'(rd_data), 32'h1A5C);

    // Both held through three read transactions: A,B,A expected.
    drv(1, 0, 2'd1, 14'h11, 1, 0, 2'd2, 14'h22);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("gnt_overlap", 32'(a_gnt && b_gnt), 32'd0);
    end
    drv(0, 0, 2'd0, 14'h0, 0, 0, 2'd0, 14'h0);
    for (int i = 0; i < 4; i++) tick();

    // B requests during A's pump.
    drv(1, 1, 2'd0, 14'h155, 0, 0, 2'd0, 14'h0);
    tick();
    drv(0, 0, 2'd0, 14'h0, 1, 0, 2'd1, 14'h0);
    for (int i = 0; i < int'(P) + 6; i++) tick();
    drv(0, 0, 2'd0, 14'h0, 0, 0, 2'd0, 14'h0);
    for (int i = 0; i < 3; i++) tick();

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      a_req       = ($urandom_range(0, 3) == 0);
      b_req       = ($urandom_range(0, 3) == 0);
      a_wr        = ($urandom_range(0, 3) == 0);
      b_wr        = ($urandom_range(0, 3) == 0);
      a_addr      = 2'($urandom);
      b_addr      = 2'($urandom);
      a_wdata     = 14'($urandom);
      b_wdata     = 14'($urandom);
      eep_rd_data = 14'($urandom);
      tick();
    end
    drv(0, 0, 2'd0, 14'h0, 0, 0, 2'd0, 14'h0);
    for (int i = 0; i < int'(P) + 4; i++) tick();

    // Reset at pump cycle 4 of an A write.
    drv(1, 1, 2'd1, 14'h2AA, 0, 0, 2'd0, 14'h0);
    tick();
    drv(0, 0, 2'd0, 14'h0, 0, 0, 2'd0, 14'h0);
    for (int i = 0; i < 4; i++) tick();
    chk("pump_before_rst", 32'(chrg_pmp_en), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare();
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    drv(1, 0, 2'd3, 14'h0, 1, 0, 2'd0, 14'h0);
    tick();
    chk("a_first_after_rst", 32'(a_gnt), 32'd1);
    drv(0, 0, 2'd0, 14'h0, 0, 0, 2'd0, 14'h0);
    for (int i = 0; i < 4; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eep_arb.md
EEP_ARB -- requirements
Module: eep_arb

Interface
REQ-001 Parameter PMP_CYCLES, default 1024: number of clk cycles chrg_pmp_en is held high per EEPROM write; legal range 1 to 65535.
REQ-002 clk  in  1  sole clock; all state changes on the rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 a_req, a_wr  in  1,1  requester A (PID control sequencer) access request and write flag (1=write, 0=read).
REQ-005 a_addr, a_wdata  in  2,14  requester A EEPROM address and write data.
REQ-006 a_gnt, a_done  out  1,1  requester A grant pulse and completion pulse.
REQ-007 b_req, b_wr, b_addr, b_wdata  in  1,1,2,14  requester B (command/config handler) request, same meaning as the A signals.
REQ-008 b_gnt, b_done  out  1,1  requester B grant pulse and completion pulse.
REQ-009 rd_data  out  14  data returned by the most recent completed read.
REQ-010 eep_rd_data  in  14  EEPROM read data, valid during the access cycle.
REQ-011 eep_cs_n, eep_r_w_n  out  1,1  EEPROM chip select (active-low) and read/write select (1=read).
REQ-012 eep_addr, eep_wr_data  out  2,14  EEPROM address and write data.
REQ-013 chrg_pmp_en  out  1  charge pump enable for EEPROM writes.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have four states: IDLE, ACCESS, PUMP and DONE; every EEPROM-side output SHALL be driven by a register, so outputs are glitch-free.
REQ-016 In IDLE, at a clock edge where at least one req is high, the FSM SHALL grant exactly one requester, latch that requester's wr/addr/wdata, and enter ACCESS.
REQ-017 Arbitration SHALL be round-robin: on a conflict, the requester not granted last wins; the last-granted pointer SHALL reset to B so that A wins the first conflict.
REQ-018 The gnt of the winning requester SHALL be high for exactly the first ACCESS cycle; the two gnt outputs SHALL never be high together.
REQ-019 In ACCESS, outputs SHALL be: eep_cs_n=0, eep_r_w_n=~latched wr, eep_addr=latched addr, eep_wr_data=latched wdata; ACCESS SHALL last exactly 1 cycle.
REQ-020 Read path: at the end of ACCESS, rd_data SHALL capture eep_rd_data and the FSM SHALL go to DONE.
REQ-021 Write path: at the end of ACCESS, the FSM SHALL go to PUMP, with eep_cs_n=1 and chrg_pmp_en=1 for exactly PMP_CYCLES cycles, then go to DONE.
REQ-022 The pump counter SHALL be 16 bits, SHALL load at ACCESS exit and SHALL count down to 1; it SHALL not wrap or underflow.
REQ-023 In DONE, the granted requester's done SHALL be high for 1 cycle, then the FSM SHALL return to IDLE; arbitration SHALL NOT occur in DONE.
REQ-024 Timing from req sampled at edge 0: a read SHALL give gnt in cycle 1 and done in cycle 2; a write SHALL give gnt in cycle 1, pump in cycles 2..PMP_CYCLES+1 and done in cycle PMP_CYCLES+2.
REQ-025 rd_data SHALL hold its value until the next read completes; writes SHALL NOT change rd_data.
REQ-026 Requests SHALL be sampled only in IDLE; req may drop after gnt without effect, and a req that drops before grant SHALL produce no access.
REQ-027 A requester that holds req high through its own done SHALL be arbitrated again in the next IDLE cycle like any other request.
REQ-028 Outside ACCESS: eep_cs_n=1, eep_r_w_n=1, and eep_addr/eep_wr_data SHALL hold their last values.

Reset
REQ-029 While rst is high, the block SHALL be asynchronously forced to: state IDLE, pointer=B, counter 0, rd_data 0, eep_addr 0, eep_wr_data 0, eep_cs_n=1, eep_r_w_n=1, chrg_pmp_en=0, busy=0, all gnt/done=0.
REQ-030 Reset asserted mid-PUMP SHALL drop chrg_pmp_en in the same cycle without waiting for a clock edge, and SHALL not generate any done pulse; the aborted transaction SHALL NOT be retried.

Verification
REQ-031 A reads addr 2, EEPROM returns 14'h1A5C -> a_gnt in cycle 1, eep_cs_n=0 and eep_r_w_n=1 in cycle 1, a_done in cycle 2, rd_data=14'h1A5C.
REQ-032 PMP_CYCLES=8; B writes 14'h3FFF to addr 3 -> eep_r_w_n=0 in cycle 1, chrg_pmp_en high for exactly cycles 2-9, b_done in cycle 10, rd_data unchanged.
REQ-033 a_req and b_req asserted together and held for 3 transactions -> grants alternate A,B,A; gnt never overlaps; one gnt per access.
REQ-034 b_req asserted during A's pump -> B is not granted until the IDLE cycle following a_done.
REQ-035 rst pulsed mid-PUMP (PMP_CYCLES=8, at pump cycle 4) -> chrg_pmp_en falls asynchronously, no done, busy=0; the next A read after reset is granted first.
